// File: rtl/banked_register_file.sv
// banked_register_file: ARM-style register file with mode-banked R8-R14,
// per-mode SPSRs, NUM_READ combinational read ports with write bypass, two
// write ports, PC auto-advance with stall, CPSR and single-cycle exception
// entry. NUM_READ is expected in the range 1-4.
module banked_register_file #(
  parameter int          WORD_SIZE  = 32,
  parameter int          ADDR_WIDTH = 4,
  parameter int          NUM_READ   = 3,
  parameter int          PC_STEP    = 4,
  parameter int unsigned RESET_PC   = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_READ*WORD_SIZE-1:0]  rd_data,
  input  logic                           wa_we,
  input  logic [ADDR_WIDTH-1:0]          wa_addr,
  input  logic [WORD_SIZE-1:0]           wa_data,
  input  logic                           wb_we,
  input  logic [ADDR_WIDTH-1:0]          wb_addr,
  input  logic [WORD_SIZE-1:0]           wb_data,
  input  logic                           user_bank,
  input  logic                           pc_we,
  input  logic [WORD_SIZE-1:0]           pc_in,
  input  logic                           stall,
  input  logic                           cpsr_we,
  input  logic [WORD_SIZE-1:0]           cpsr_in,
  input  logic                           cpsr_flags_we,
  input  logic                           spsr_we,
  input  logic [WORD_SIZE-1:0]           spsr_in,
  input  logic                           spsr_restore,
  input  logic                           exc_req,
  input  logic [4:0]                     exc_mode,
  input  logic [WORD_SIZE-1:0]           exc_vector,
  input  logic [WORD_SIZE-1:0]           exc_ret_addr,
  output logic [WORD_SIZE-1:0]           pc_out,
  output logic [WORD_SIZE-1:0]           cpsr_out,
  output logic [WORD_SIZE-1:0]           spsr_out
);

  // Physical map: 0-14 USR R0-R14, 15-21 FIQ R8-R14, 22-23 IRQ R13-R14,
  // 24-25 SVC R13-R14. R15 is the separate pc_reg.
  localparam int NUM_PHYS = 26;
  localparam logic [4:0] MODE_FIQ = 5'b10001;
  localparam logic [4:0] MODE_IRQ = 5'b10010;
  localparam logic [4:0] MODE_SVC = 5'b10011;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR = ADDR_WIDTH'(15);
  localparam logic [ADDR_WIDTH-1:0] LR_ADDR = ADDR_WIDTH'(14);
  localparam logic [WORD_SIZE-1:0]  CPSR_RESET = WORD_SIZE'(32'h0000_00D3);

  typedef enum logic [1:0] {BANK_USR, BANK_FIQ, BANK_IRQ, BANK_SVC} bank_e;

  // USR, SYS and every undefined encoding share the USR bank
  function automatic bank_e mode_bank(input logic [4:0] m);
    case (m)
      MODE_FIQ: return BANK_FIQ;
      MODE_IRQ: return BANK_IRQ;
      MODE_SVC: return BANK_SVC;
      default:  return BANK_USR;
    endcase
  endfunction

  // Logical register -> physical slot; callers never pass R15
  function automatic logic [4:0] phys_idx(input bank_e b, input logic [ADDR_WIDTH-1:0] a);
    logic [4:0] a5;
    a5 = 5'(a);
    phys_idx = a5;
    case (b)
      BANK_FIQ: if (a5 >= 5'd8)  phys_idx = a5 + 5'd7;
      BANK_IRQ: if (a5 >= 5'd13) phys_idx = a5 + 5'd9;
      BANK_SVC: if (a5 >= 5'd13) phys_idx = a5 + 5'd11;
      default:  phys_idx = a5;
    endcase
  endfunction

  logic [WORD_SIZE-1:0] regs_reg [NUM_PHYS];
  logic [WORD_SIZE-1:0] spsr_fiq_reg, spsr_irq_reg, spsr_svc_reg;
  logic [WORD_SIZE-1:0] pc_reg, pc_next, cpsr_reg, cpsr_next, cur_spsr;
  bank_e                cur_bank, port_bank, exc_bank;
  logic                 has_spsr, exc_accept, a_wr, b_wr, a_gpr, b_gpr;

  assign cur_bank   = mode_bank(cpsr_reg[4:0]);
  assign port_bank  = user_bank ? BANK_USR : cur_bank;
  assign has_spsr   = (cur_bank != BANK_USR);
  assign exc_bank   = mode_bank(exc_mode);
  assign exc_accept = exc_req && (exc_bank != BANK_USR);

  // An accepted exception discards both write ports; A wins an address clash
  assign a_wr  = wa_we && !exc_accept;
  assign b_wr  = wb_we && !exc_accept && !(a_wr && (wa_addr == wb_addr));
  assign a_gpr = a_wr && (wa_addr != PC_ADDR);
  assign b_gpr = b_wr && (wb_addr != PC_ADDR);

  // Current mode's SPSR, zero when the mode has none
  always_comb begin
    cur_spsr = '0;
    case (cur_bank)
      BANK_FIQ: cur_spsr = spsr_fiq_reg;
      BANK_IRQ: cur_spsr = spsr_irq_reg;
      BANK_SVC: cur_spsr = spsr_svc_reg;
      default:  cur_spsr = '0;
    endcase
  end

  // Read ports: write bypass (A before B), then R15, then banked storage
  genvar gi;
  generate
    for (gi = 0; gi < NUM_READ; gi++) begin : g_read
      logic [ADDR_WIDTH-1:0] addr;
      logic [WORD_SIZE-1:0]  data;
      assign addr = rd_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
      // Combinational operand fetch for this port
      always_comb begin
        data = '0;
        if (wa_we && (wa_addr == addr))      data = wa_data;
        else if (wb_we && (wb_addr == addr)) data = wb_data;
        else if (addr == PC_ADDR)            data = pc_reg;
        else                                 data = regs_reg[phys_idx(port_bank, addr)];
      end
      assign rd_data[gi*WORD_SIZE +: WORD_SIZE] = data;
    end
  endgenerate

  // PC next value in priority order
  always_comb begin
    pc_next = pc_reg + WORD_SIZE'(PC_STEP);
    if (exc_accept)                           pc_next = exc_vector;
    else if (a_wr && (wa_addr == PC_ADDR))    pc_next = wa_data;
    else if (wb_we && (wb_addr == PC_ADDR))   pc_next = wb_data;
    else if (pc_we)                           pc_next = pc_in;
    else if (stall)                           pc_next = pc_reg;
  end

  // CPSR next value in priority order
  always_comb begin
    cpsr_next = cpsr_reg;
    if (exc_accept) begin
      cpsr_next[4:0] = exc_mode;
      cpsr_next[7]   = 1'b1;
      if (exc_bank == BANK_FIQ) cpsr_next[6] = 1'b1;
    end else if (spsr_restore && has_spsr) begin
      cpsr_next = cur_spsr;
    end else if (cpsr_we) begin
      cpsr_next = cpsr_in;
    end else if (cpsr_flags_we) begin
      cpsr_next[WORD_SIZE-1:WORD_SIZE-4] = cpsr_in[WORD_SIZE-1:WORD_SIZE-4];
    end
  end

  // State update: registers, SPSRs, PC and CPSR
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++) regs_reg[i] <= '0;
      spsr_fiq_reg <= '0;
      spsr_irq_reg <= '0;
      spsr_svc_reg <= '0;
      pc_reg       <= WORD_SIZE'(RESET_PC);
      cpsr_reg     <= CPSR_RESET;
    end else begin
      pc_reg   <= pc_next;
      cpsr_reg <= cpsr_next;
      if (b_gpr) regs_reg[phys_idx(port_bank, wb_addr)] <= wb_data;
      if (a_gpr) regs_reg[phys_idx(port_bank, wa_addr)] <= wa_data;
      if (exc_accept) begin
        regs_reg[phys_idx(exc_bank, LR_ADDR)] <= exc_ret_addr;
        case (exc_bank)
          BANK_FIQ: spsr_fiq_reg <= cpsr_reg;
          BANK_IRQ: spsr_irq_reg <= cpsr_reg;
          BANK_SVC: spsr_svc_reg <= cpsr_reg;
          default:  ;
        endcase
      end else if (spsr_we) begin
        case (cur_bank)
          BANK_FIQ: spsr_fiq_reg <= spsr_in;
          BANK_IRQ: spsr_irq_reg <= spsr_in;
          BANK_SVC: spsr_svc_reg <= spsr_in;
          default:  ;
        endcase
      end
    end
  end

  assign pc_out   = pc_reg;
  assign cpsr_out = cpsr_reg;
  assign spsr_out = cur_spsr;

endmodule

// File: tb/tb_banked_register_file.sv
// Directed bench for banked_register_file with a queue-based scoreboard.
module tb_banked_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [11:0] rd_addr;
  logic [95:0] rd_data;
  logic        wa_we, wb_we, user_bank, pc_we, stall, cpsr_we, cpsr_flags_we;
  logic        spsr_we, spsr_restore, exc_req;
  logic [3:0]  wa_addr, wb_addr;
  logic [31:0] wa_data, wb_data, pc_in, cpsr_in, spsr_in, exc_vector, exc_ret_addr;
  logic [4:0]  exc_mode;
  logic [31:0] pc_out, cpsr_out, spsr_out;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  banked_register_file #(
    .WORD_SIZE(32), .ADDR_WIDTH(4), .NUM_READ(3), .PC_STEP(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wa_we(wa_we), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .user_bank(user_bank), .pc_we(pc_we), .pc_in(pc_in), .stall(stall),
    .cpsr_we(cpsr_we), .cpsr_in(cpsr_in), .cpsr_flags_we(cpsr_flags_we),
    .spsr_we(spsr_we), .spsr_in(spsr_in), .spsr_restore(spsr_restore),
    .exc_req(exc_req), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_ret_addr(exc_ret_addr), .pc_out(pc_out), .cpsr_out(cpsr_out),
    .spsr_out(spsr_out)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $error("FAIL scoreboard_underflow: observed %h with no expected value", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
      $display("[TB] %s observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic clear_ctl();
    wa_we = 0; wb_we = 0; pc_we = 0; cpsr_we = 0; cpsr_flags_we = 0;
    spsr_we = 0; spsr_restore = 0; exc_req = 0; user_bank = 0;
    wa_addr = 0; wb_addr = 0; wa_data = 0; wb_data = 0; pc_in = 0;
    cpsr_in = 0; spsr_in = 0; exc_mode = 0; exc_vector = 0; exc_ret_addr = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply the driven inputs for one edge, then return to idle
  task automatic step();
    tick();
    clear_ctl();
    #1;
  endtask

  task automatic set_rd(input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2);
    rd_addr = {a2, a1, a0};
  endtask

  function automatic logic [31:0] rd(input int k);
    return rd_data[k*32 +: 32];
  endfunction

  initial begin
    clear_ctl();
    stall = 0;
    rd_addr = '0;
    reset = 1;
    repeat (2) tick();
    reset = 0;
    #1;

    // Reset state and free-running PC
    expect_v("reset_pc", 32'h0);
    expect_v("reset_cpsr", 32'h0000_00D3);
    chk(pc_out);
    chk(cpsr_out);
    set_rd(4'd15, 4'd5, 4'd13);
    #1;
    expect_v("reset_r15", 32'h0);
    expect_v("reset_r5", 32'h0);
    chk(rd(0));
    chk(rd(1));
    expect_v("pc_run1", 32'h4);  tick(); chk(pc_out);
    expect_v("pc_run2", 32'h8);  tick(); chk(pc_out);
    expect_v("pc_run3", 32'hC);  tick(); chk(pc_out);
    expect_v("r15_read", 32'hC); chk(rd(0));
    expect_v("cpsr_run", 32'h0000_00D3); chk(cpsr_out);
    stall = 1;
    expect_v("pc_stall1", 32'hC); tick(); chk(pc_out);
    expect_v("pc_stall2", 32'hC); tick(); chk(pc_out);

    // Banking of R13 between SVC and USR, shared R12
    wa_we = 1; wa_addr = 13; wa_data = 32'hAAAA_0000;
    wb_we = 1; wb_addr = 12; wb_data = 32'h1212_1212;
    step();
    cpsr_we = 1; cpsr_in = 32'h10;
    step();
    wa_we = 1; wa_addr = 13; wa_data = 32'h1111_0000;
    step();
    set_rd(4'd13, 4'd12, 4'd15);
    #1;
    expect_v("usr_r13", 32'h1111_0000);
    expect_v("usr_r12", 32'h1212_1212);
    chk(rd(0));
    chk(rd(1));
    cpsr_we = 1; cpsr_in = 32'hD3;
    step();
    expect_v("svc_r13", 32'hAAAA_0000);
    expect_v("svc_r12", 32'h1212_1212);
    chk(rd(0));
    chk(rd(1));
    user_bank = 1;
    #1;
    expect_v("user_bank_r13", 32'h1111_0000);
    chk(rd(0));
    user_bank = 0;

    // Dual write to the same register: A wins, bypass and stored value
    wa_we = 1; wa_addr = 3; wa_data = 32'd5;
    wb_we = 1; wb_addr = 3; wb_data = 32'd7;
    set_rd(4'd3, 4'd12, 4'd15);
    #1;
    expect_v("bypass_conflict", 32'd5);
    chk(rd(0));
    step();
    expect_v("stored_conflict", 32'd5);
    chk(rd(0));
    wb_we = 1; wb_addr = 4; wb_data = 32'd9;
    set_rd(4'd4, 4'd3, 4'd15);
    #1;
    expect_v("bypass_b", 32'd9);
    chk(rd(0));
    step();
    expect_v("stored_b", 32'd9);
    chk(rd(0));

    // FIQ entry from USR with flags set; concurrent writes are discarded
    wa_we = 1; wa_addr = 8; wa_data = 32'h8888_8888;
    cpsr_we = 1; cpsr_in = 32'h6000_0010;
    step();
    exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C; exc_ret_addr = 32'h104;
    wa_we = 1; wa_addr = 0; wa_data = 32'hDEAD;
    cpsr_we = 1; cpsr_in = 32'h0;
    expect_v("fiq_pc", 32'h1C);
    expect_v("fiq_cpsr", 32'h6000_00D1);
    expect_v("fiq_spsr", 32'h6000_0010);
    step();
    chk(pc_out);
    chk(cpsr_out);
    chk(spsr_out);
    set_rd(4'd14, 4'd8, 4'd0);
    #1;
    expect_v("fiq_lr", 32'h104);
    expect_v("fiq_r8", 32'h0);
    expect_v("fiq_discarded_r0", 32'h0);
    chk(rd(0));
    chk(rd(1));
    chk(rd(2));

    // Return from FIQ with a branch
    spsr_restore = 1; pc_we = 1; pc_in = 32'h100;
    expect_v("restore_cpsr", 32'h6000_0010);
    expect_v("restore_pc", 32'h100);
    expect_v("restore_spsr_usr", 32'h0);
    step();
    chk(cpsr_out);
    chk(pc_out);
    chk(spsr_out);
    set_rd(4'd8, 4'd14, 4'd0);
    #1;
    expect_v("usr_r8_kept", 32'h8888_8888);
    expect_v("usr_r14", 32'h0);
    chk(rd(0));
    chk(rd(1));
    cpsr_flags_we = 1; cpsr_in = 32'h9FFF_FFFF;
    expect_v("flags_only", 32'h9000_0010);
    step();
    chk(cpsr_out);

    // PC wrap and ignored exception with invalid mode
    pc_we = 1; pc_in = 32'hFFFF_FFFC;
    expect_v("pc_load_top", 32'hFFFF_FFFC);
    step();
    chk(pc_out);
    stall = 0;
    expect_v("pc_wrap", 32'h0);
    tick();
    chk(pc_out);
    exc_req = 1; exc_mode = 5'b10111; exc_vector = 32'h50; exc_ret_addr = 32'h999;
    expect_v("bad_exc_pc", 32'h4);
    expect_v("bad_exc_cpsr", 32'h9000_0010);
    step();
    chk(pc_out);
    chk(cpsr_out);
    stall = 1;

    // IRQ entry banks only R13/R14
    exc_req = 1; exc_mode = 5'b10010; exc_vector = 32'h18; exc_ret_addr = 32'h204;
    expect_v("irq_pc", 32'h18);
    expect_v("irq_cpsr", 32'h9000_0092);
    expect_v("irq_spsr", 32'h9000_0010);
    step();
    chk(pc_out);
    chk(cpsr_out);
    chk(spsr_out);
    set_rd(4'd14, 4'd13, 4'd8);
    #1;
    expect_v("irq_lr", 32'h204);
    expect_v("irq_r13", 32'h0);
    expect_v("irq_r8_shared", 32'h8888_8888);
    chk(rd(0));
    chk(rd(1));
    chk(rd(2));
    spsr_we = 1; spsr_in = 32'h1234;
    expect_v("irq_spsr_we", 32'h1234);
    step();
    chk(spsr_out);

    // PC source priority
    wa_we = 1; wa_addr = 15; wa_data = 32'h300;
    wb_we = 1; wb_addr = 15; wb_data = 32'h500;
    pc_we = 1; pc_in = 32'h400;
    expect_v("pc_prio_a", 32'h300);
    step();
    chk(pc_out);
    wb_we = 1; wb_addr = 15; wb_data = 32'h500;
    pc_we = 1; pc_in = 32'h400;
    expect_v("pc_prio_b", 32'h500);
    step();
    chk(pc_out);

    // Reset overrides concurrent activity
    reset = 1;
    wa_we = 1; wa_addr = 13; wa_data = 32'hFFFF;
    exc_req = 1; exc_mode = 5'b10001; exc_vector = 32'h1C; exc_ret_addr = 32'h1;
    cpsr_we = 1; cpsr_in = 32'h10;
    step();
    reset = 0;
    expect_v("rst2_pc", 32'h0);
    expect_v("rst2_cpsr", 32'h0000_00D3);
    expect_v("rst2_spsr", 32'h0);
    chk(pc_out);
    chk(cpsr_out);
    chk(spsr_out);
    set_rd(4'd13, 4'd8, 4'd3);
    #1;
    expect_v("rst2_r13", 32'h0);
    expect_v("rst2_r8", 32'h0);
    expect_v("rst2_r3", 32'h0);
    chk(rd(0));
    chk(rd(1));
    chk(rd(2));

    tests_run++;
    assert (sb_q.size() == 0) else begin
      tests_failed++;
      $error("FAIL scoreboard_leftover: observed %0d entries expected 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
